// File: rtl/pll_lock_reset_seq.sv
// PLL lock qualifier and reset sequencer on the free-running RC oscillator clock.
// Drives the PLL async reset, qualifies LOCK over a settle window, and keeps lock-loss/retry statistics.
module pll_lock_reset_seq #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned ARST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lock_i,
    input  logic             sw_rearm,
    input  logic             clr_stats,
    output logic             pll_arst_n,
    output logic             core_rst,
    output logic             locked,
    output logic             timeout_err,
    output logic [CNT_W-1:0] loss_cnt,
    output logic [CNT_W-1:0] retry_cnt
);

    localparam int unsigned MAX_AW = (ARST_CYCLES > LOCK_TIMEOUT) ? ARST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_ALL = (MAX_AW > SETTLE_CYCLES) ? MAX_AW : SETTLE_CYCLES;
    localparam int unsigned TW = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

    typedef enum logic [1:0] {
        ST_ARST      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_SETTLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [TW-1:0]          cnt;
    logic [TW-1:0]          cnt_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic                   restart;
    logic                   loss_evt;
    logic                   retry_evt;

    // LOCK synchroniser; the FSM only ever looks at the last stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lock_i};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    // Next state and cycle counter; sw_rearm overrides every FSM transition
    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        loss_evt  = 1'b0;
        retry_evt = 1'b0;
        cnt_nxt   = cnt;
        if (sw_rearm) begin
            state_nxt = ST_ARST;
            restart   = 1'b1;
        end else begin
            case (state)
                ST_ARST: begin
                    if (cnt == TW'(ARST_CYCLES - 1)) state_nxt = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = ST_SETTLE;
                    end else if (cnt == TW'(LOCK_TIMEOUT - 1)) begin
                        state_nxt = ST_ARST;
                        retry_evt = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (!lock_s) begin
                        state_nxt = ST_WAIT_LOCK;
                    end else if (cnt == TW'(SETTLE_CYCLES - 1)) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_nxt = ST_WAIT_LOCK;
                        loss_evt  = 1'b1;
                    end
                end
                default: state_nxt = ST_ARST;
            endcase
        end
        // RUN has no timed exit, so the counter is frozen there to avoid wrapping
        if (restart || (state_nxt != state)) begin
            cnt_nxt = '0;
        end else if (state != ST_RUN) begin
            cnt_nxt = cnt + TW'(1);
        end
    end

    // State register with outputs decoded from the next state so they move on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_ARST;
            cnt        <= '0;
            pll_arst_n <= 1'b0;
            core_rst   <= 1'b1;
            locked     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pll_arst_n <= (state_nxt != ST_ARST);
            core_rst   <= (state_nxt != ST_RUN);
            locked     <= (state_nxt == ST_RUN);
        end
    end

    // Status counters; clr_stats beats any same-cycle increment or set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err <= 1'b0;
            loss_cnt    <= '0;
            retry_cnt   <= '0;
        end else if (clr_stats) begin
            timeout_err <= 1'b0;
            loss_cnt    <= '0;
            retry_cnt   <= '0;
        end else begin
            if (retry_evt) begin
                timeout_err <= 1'b1;
                if (retry_cnt != '1) retry_cnt <= retry_cnt + CNT_W'(1);
            end
            if (loss_evt && (loss_cnt != '1)) loss_cnt <= loss_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Randomised bench for pll_lock_reset_seq against a budget-based behavioural model,
// plus directed edge-count checks for release latency, re-arm pulse width and saturation.
module tb_pll_lock_reset_seq;

    localparam int unsigned SYNC   = 2;
    localparam int unsigned ARST   = 4;
    localparam int unsigned TMO    = 20;
    localparam int unsigned SETTLE = 8;
    localparam int unsigned CW     = 4;
    localparam int          SAT    = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          lock_i = 1'b0;
    logic          sw_rearm = 1'b0;
    logic          clr_stats = 1'b0;
    logic          pll_arst_n;
    logic          core_rst;
    logic          locked;
    logic          timeout_err;
    logic [CW-1:0] loss_cnt;
    logic [CW-1:0] retry_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pll_lock_reset_seq #(
        .SYNC_STAGES  (SYNC),
        .ARST_CYCLES  (ARST),
        .LOCK_TIMEOUT (TMO),
        .SETTLE_CYCLES(SETTLE),
        .CNT_W        (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lock_i     (lock_i),
        .sw_rearm   (sw_rearm),
        .clr_stats  (clr_stats),
        .pll_arst_n (pll_arst_n),
        .core_rst   (core_rst),
        .locked     (locked),
        .timeout_err(timeout_err),
        .loss_cnt   (loss_cnt),
        .retry_cnt  (retry_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: remaining budgets for the reset pulse, lock wait and settle window, plus a run flag
    int pulse_left;
    int wait_left;
    int settle_left;
    bit run;
    bit m_terr;
    int m_loss;
    int m_retry;
    bit hist[SYNC];

    function automatic void model_reset();
        pulse_left  = ARST;
        wait_left   = 0;
        settle_left = 0;
        run         = 1'b0;
        m_terr      = 1'b0;
        m_loss      = 0;
        m_retry     = 0;
        for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
    endfunction

    function automatic void model_step();
        bit ls;
        if (rst) begin
            model_reset();
            return;
        end
        ls = hist[SYNC-1];
        if (sw_rearm) begin
            pulse_left  = ARST;
            wait_left   = 0;
            settle_left = 0;
            run         = 1'b0;
        end else if (pulse_left > 0) begin
            pulse_left--;
            if (pulse_left == 0) wait_left = TMO;
        end else if (run) begin
            if (!ls) begin
                run       = 1'b0;
                wait_left = TMO;
                if (m_loss < SAT) m_loss++;
            end
        end else if (settle_left > 0) begin
            if (!ls) begin
                settle_left = 0;
                wait_left   = TMO;
            end else begin
                settle_left--;
                if (settle_left == 0) run = 1'b1;
            end
        end else begin
            if (ls) begin
                settle_left = SETTLE;
                wait_left   = 0;
            end else begin
                wait_left--;
                if (wait_left == 0) begin
                    pulse_left = ARST;
                    m_terr     = 1'b1;
                    if (m_retry < SAT) m_retry++;
                end
            end
        end
        if (clr_stats) begin
            m_terr  = 1'b0;
            m_loss  = 0;
            m_retry = 0;
        end
        for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = lock_i;
    endfunction

    task automatic compare_all();
        check("pll_arst_n", pll_arst_n, pulse_left == 0);
        check("core_rst", core_rst, !run);
        check("locked", locked, run);
        check("timeout_err", timeout_err, m_terr);
        check("loss_cnt", loss_cnt, m_loss);
        check("retry_cnt", retry_cnt, m_retry);
    endtask

    // One clock: model follows the edge, outputs are compared 1 time unit later, pulses drop
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        sw_rearm  = 1'b0;
        clr_stats = 1'b0;
    endtask

    task automatic edges_until_core(input logic val, output int n);
        n = 0;
        while (core_rst !== val && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic edges_until_arst_n(input logic val, output int n);
        n = 0;
        while (pll_arst_n !== val && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic async_reset_pulse(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_pll_arst_n"}, pll_arst_n, 1'b0);
        check({tag, "_core_rst"}, core_rst, 1'b1);
        check({tag, "_locked"}, locked, 1'b0);
        check({tag, "_stats"}, {timeout_err, loss_cnt, retry_cnt}, '0);
        model_reset();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int arst_hi;
        int fall_at;
        int seg_left;

        // Scenario 1: reset, lock 3 cycles after release
        #2;
        rst = 1'b1;
        #1;
        check("rst_pll_arst_n", pll_arst_n, 1'b0);
        check("rst_core_rst", core_rst, 1'b1);
        check("rst_locked", locked, 1'b0);
        check("rst_stats", {timeout_err, loss_cnt, retry_cnt}, '0);
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        arst_hi = -1;
        fall_at = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (pll_arst_n && arst_hi < 0) arst_hi = i;
            if (!core_rst && fall_at < 0) fall_at = i;
            if (i == 3) lock_i = 1'b1;
        end
        check("arst_pulse_len", arst_hi, 4);
        check("lock_to_release", fall_at - 3, SYNC + SETTLE + 1);
        check("s1_locked", locked, 1'b1);
        check("s1_counters", {loss_cnt, retry_cnt}, '0);

        // Scenario 3: 5-cycle lock drop in RUN
        lock_i = 1'b0;
        edges_until_core(1'b1, n);
        check("loss_to_core_rst", n, 3);
        tick();
        tick();
        lock_i = 1'b1;
        edges_until_core(1'b0, n);
        check("restore_to_release", n, 11);
        check("s3_loss_cnt", loss_cnt, 1);

        // Scenario 4: lock drops while settle count is 5
        lock_i = 1'b0;
        edges_until_core(1'b1, n);
        tick();
        tick();
        lock_i = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        lock_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("s4_core_rst_held", core_rst, 1'b1);
        end
        lock_i = 1'b1;
        edges_until_core(1'b0, n);
        check("s4_settle_restart", n, 11);
        check("s4_loss_cnt", loss_cnt, 2);

        // Scenario 5: one more loss, then sw_rearm together with clr_stats in RUN
        lock_i = 1'b0;
        edges_until_core(1'b1, n);
        lock_i = 1'b1;
        edges_until_core(1'b0, n);
        check("s5_loss_pre", loss_cnt, 3);
        sw_rearm  = 1'b1;
        clr_stats = 1'b1;
        tick();
        check("s5_core_rst", core_rst, 1'b1);
        check("s5_pll_arst_n", pll_arst_n, 1'b0);
        check("s5_cleared", {timeout_err, loss_cnt}, '0);
        edges_until_arst_n(1'b1, n);
        check("s5_rearm_pulse", n, 4);

        // Scenario 2: lock never returns; retry count saturates
        clr_stats = 1'b1;
        lock_i    = 1'b0;
        tick();
        for (int i = 0; i < 15 * 24 + 60; i++) tick();
        check("s2_timeout_err", timeout_err, 1'b1);
        check("s2_retry_sat", retry_cnt, 15);

        // Scenario 6: async reset in SETTLE
        edges_until_arst_n(1'b1, n);
        lock_i = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        async_reset_pulse("s6");

        // Randomised segments of lock level with sparse control pulses and resets
        seg_left = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (seg_left == 0) begin
                if ($urandom_range(0, 9) < 7) begin
                    lock_i   = 1'b1;
                    seg_left = $urandom_range(1, 60);
                end else begin
                    lock_i   = 1'b0;
                    seg_left = $urandom_range(1, 30);
                end
            end
            seg_left--;
            if ($urandom_range(0, 149) == 0) sw_rearm = 1'b1;
            if ($urandom_range(0, 99) == 0) clr_stats = 1'b1;
            if ($urandom_range(0, 499) == 0) begin
                sw_rearm  = 1'b0;
                clr_stats = 1'b0;
                async_reset_pulse("rnd_rst");
            end else begin
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
